// File: rtl/regfile_scoreboard_pkg.sv
// Shared definitions for the ID-stage register file with its pending-write scoreboard.
package regfile_scoreboard_pkg;

    // Address width needed to index a register file of the given depth.
    function automatic int addr_width(input int size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

    // Architectural register numbers used by ID-stage consumers.
    localparam int REG_PC = 15;
    localparam int REG_LR = 14;

endpackage

// File: rtl/sb_counter.sv
// One pending-write counter: counts issued-but-not-retired writes to a single register.
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             full,
    output logic             underflow
);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    // Simultaneous issue and retire cancel; a retire with nothing pending leaves the count at zero.
    always_comb begin
        cnt_next = cnt_reg;
        if (flush) begin
            cnt_next = '0;
        end else if (inc && !dec && !full) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end else if (dec && !inc && (cnt_reg != '0)) begin
            cnt_next = cnt_reg - CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign cnt       = cnt_reg;
    assign full      = (cnt_reg == '1);
    // A retire that matches no outstanding issue; flush squashes the bookkeeping, so it is not an error then.
    assign underflow = dec && !inc && !flush && (cnt_reg == '0);

endmodule

// File: rtl/regfile_scoreboard.sv
// ID-stage register file: combinational read ports with optional writeback bypass,
// plus per-register pending-write counters that drive read-port busy flags.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter  int WIDTH       = 32,
    parameter  int SIZE        = 16,
    parameter  int NUM_RD      = 3,
    parameter  int CNT_W       = 2,
    parameter  int BYPASS      = 1,
    parameter  int RESET_INDEX = 1,
    localparam int AW          = addr_width(SIZE)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    freeze,
    input  logic                    flush,
    input  logic [NUM_RD*AW-1:0]    rd_addr,
    output logic [NUM_RD*WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]       rd_busy,
    input  logic                    wb_en,
    input  logic [AW-1:0]           wb_addr,
    input  logic [WIDTH-1:0]        wb_data,
    input  logic                    iss_en,
    input  logic [AW-1:0]           iss_addr,
    output logic                    iss_full,
    output logic                    sb_err
);

    logic [WIDTH-1:0]            mem_reg [SIZE];
    logic [SIZE-1:0][CNT_W-1:0]  cnt;
    logic [SIZE-1:0]             full_vec;
    logic [SIZE-1:0]             uf_vec;
    logic                        iss_ok;
    logic                        sb_err_reg;

    // A retire to the same register this cycle frees a slot, so a saturated counter may still accept.
    assign iss_full = full_vec[iss_addr] && !(wb_en && (wb_addr == iss_addr));
    assign iss_ok   = iss_en && !freeze && !flush && !iss_full;

    // Register array: reset image, then writeback regardless of freeze.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SIZE; i++) begin
                mem_reg[i] <= (RESET_INDEX != 0) ? WIDTH'(i) : '0;
            end
        end else if (wb_en) begin
            mem_reg[wb_addr] <= wb_data;
        end
    end

    genvar gi;

    generate
        for (gi = 0; gi < SIZE; gi++) begin : g_cnt
            logic inc;
            logic dec;

            assign inc = iss_ok && (iss_addr == AW'(gi));
            assign dec = wb_en && (wb_addr == AW'(gi));

            sb_counter #(
                .CNT_W(CNT_W)
            ) u_cnt (
                .clk      (clk),
                .rst      (rst),
                .flush    (flush),
                .inc      (inc),
                .dec      (dec),
                .cnt      (cnt[gi]),
                .full     (full_vec[gi]),
                .underflow(uf_vec[gi])
            );
        end
    endgenerate

    // Sticky scoreboard error; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_err_reg <= 1'b0;
        end else if (|uf_vec) begin
            sb_err_reg <= 1'b1;
        end
    end

    assign sb_err = sb_err_reg;

    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [AW-1:0] ra;
            logic          hit;

            assign ra  = rd_addr[gi*AW +: AW];
            assign hit = (BYPASS != 0) && wb_en && (wb_addr == ra);
            assign rd_data[gi*WIDTH +: WIDTH] = hit ? wb_data : mem_reg[ra];
            // A hit only satisfies the reader when it is the last outstanding write.
            assign rd_busy[gi] = (cnt[ra] != '0) && !(hit && (cnt[ra] == CNT_W'(1)));
        end
    endgenerate

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard with a behavioural reference model checked every cycle.
module tb_regfile_scoreboard;
    import regfile_scoreboard_pkg::*;

    logic        clk = 1'b0;
    logic        rst, freeze, flush, wb_en, iss_en;
    logic [11:0] rd_addr;
    logic [3:0]  wb_addr, iss_addr;
    logic [31:0] wb_data;
    logic [95:0] rd_data, rd_data_nb;
    logic [2:0]  rd_busy, rd_busy_nb;
    logic        iss_full, iss_full_nb, sb_err, sb_err_nb;

    int n_checks = 0;
    int n_errors = 0;
    bit armed = 1'b0;

    // Reference state: register contents, in-flight write counts, sticky error.
    logic [31:0] m_mem [16];
    int          m_cnt [16];
    bit          m_err;

    always #5 clk = ~clk;

    regfile_scoreboard #(.BYPASS(1)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .iss_full(iss_full), .sb_err(sb_err)
    );

    regfile_scoreboard #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .iss_full(iss_full_nb), .sb_err(sb_err_nb)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h at t=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic [3:0] port_addr(input int k);
        logic [11:0] a;
        a = rd_addr;
        return a[k*4 +: 4];
    endfunction

    function automatic logic [31:0] m_data(input int k, input bit byp);
        logic [3:0] a;
        a = port_addr(k);
        return (byp && wb_en && wb_addr == a) ? wb_data : m_mem[a];
    endfunction

    function automatic logic m_busy(input int k, input bit byp);
        logic [3:0] a;
        bit hit;
        a = port_addr(k);
        hit = byp && wb_en && wb_addr == a;
        return (m_cnt[a] > 0) && !(hit && m_cnt[a] == 1);
    endfunction

    function automatic logic m_full();
        return (m_cnt[iss_addr] == 3) && !(wb_en && wb_addr == iss_addr);
    endfunction

    // Model update on each rising edge from the inputs held during that cycle.
    always @(posedge clk) begin
        bit ok;
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                m_mem[i] = 32'(i);
                m_cnt[i] = 0;
            end
            m_err = 1'b0;
        end else begin
            ok = iss_en && !freeze && !flush && !m_full();
            if (wb_en) m_mem[wb_addr] = wb_data;
            if (flush) begin
                for (int i = 0; i < 16; i++) m_cnt[i] = 0;
            end else if (!(ok && wb_en && iss_addr == wb_addr)) begin
                if (ok) m_cnt[iss_addr] = m_cnt[iss_addr] + 1;
                if (wb_en) begin
                    if (m_cnt[wb_addr] > 0) m_cnt[wb_addr] = m_cnt[wb_addr] - 1;
                    else m_err = 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison of both DUTs against the model.
    always @(negedge clk) begin
        if (armed) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("model rd_data%0d", k), rd_data[k*32 +: 32], m_data(k, 1'b1));
                chk($sformatf("model nb rd_data%0d", k), rd_data_nb[k*32 +: 32], m_data(k, 1'b0));
                chk($sformatf("model rd_busy%0d", k), 32'(rd_busy[k]), 32'(m_busy(k, 1'b1)));
                chk($sformatf("model nb rd_busy%0d", k), 32'(rd_busy_nb[k]), 32'(m_busy(k, 1'b0)));
            end
            chk("model iss_full", 32'(iss_full), 32'(m_full()));
            chk("model nb iss_full", 32'(iss_full_nb), 32'(m_full()));
            chk("model sb_err", 32'(sb_err), 32'(m_err));
            chk("model nb sb_err", 32'(sb_err_nb), 32'(m_err));
        end
    end

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic to_next();
        $display("txn t=%0t rst=%0b wb=%0b/%0d/%h iss=%0b/%0d frz=%0b fl=%0b rd=%h",
                 $time, rst, wb_en, wb_addr, wb_data, iss_en, iss_addr, freeze, flush, rd_addr);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; freeze = 0; flush = 0; wb_en = 0; iss_en = 0;
    endtask

    task automatic set_rd(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2);
        rd_addr = {a2, a1, a0};
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        rst = 1; wb_addr = 0; wb_data = 0; iss_addr = 0; rd_addr = 0;
        to_next();
        to_next();
        idle();
        armed = 1'b1;

        // Reset contents and idle flags.
        set_rd(0, 7, 4'(REG_PC));
        to_neg();
        chk("reset rd_data0", rd_data[31:0], 32'd0);
        chk("reset rd_data1", rd_data[63:32], 32'd7);
        chk("reset rd_data2", rd_data[95:64], 32'd15);
        chk("reset rd_busy", 32'(rd_busy), 32'd0);
        chk("reset iss_full", 32'(iss_full), 32'd0);
        chk("reset sb_err", 32'(sb_err), 32'd0);
        to_next();

        // Bypass vs. no bypass on a same-cycle writeback.
        iss_en = 1; iss_addr = 3;
        to_next();
        iss_en = 0;
        wb_en = 1; wb_addr = 3; wb_data = 32'hDEADBEEF; set_rd(3, 0, 1);
        to_neg();
        chk("bypass rd_data0", rd_data[31:0], 32'hDEADBEEF);
        chk("nobypass rd_data0", rd_data_nb[31:0], 32'd3);
        chk("bypass busy0", 32'(rd_busy[0]), 32'd0);
        chk("nobypass busy0", 32'(rd_busy_nb[0]), 32'd1);
        to_next();
        wb_en = 0;
        to_neg();
        chk("nobypass rd_data0 next", rd_data_nb[31:0], 32'hDEADBEEF);
        to_next();

        // Single pending write to r5, then satisfied by a writeback.
        iss_en = 1; iss_addr = 5; set_rd(5, 5, 5);
        to_next();
        iss_en = 0;
        to_next();
        to_neg();
        chk("r5 busy", 32'(rd_busy), 32'd7);
        to_next();
        wb_en = 1; wb_addr = 5; wb_data = 32'h55;
        to_neg();
        chk("r5 wb busy", 32'(rd_busy), 32'd0);
        chk("r5 wb rd_data0", rd_data[31:0], 32'h55);
        to_next();
        wb_en = 0;

        // Saturate r5.
        iss_en = 1; iss_addr = 5;
        to_next();
        to_next();
        to_next();
        to_neg();
        chk("r5 full", 32'(iss_full), 32'd1);
        to_next();
        iss_en = 0;
        to_neg();
        chk("r5 full held", 32'(iss_full), 32'd1);
        to_next();
        iss_en = 1; wb_en = 1; wb_addr = 5; wb_data = 32'h501;
        to_neg();
        chk("r5 full freed", 32'(iss_full), 32'd0);
        chk("r5 busy on old hit", 32'(rd_busy[0]), 32'd1);
        to_next();
        iss_en = 0; wb_en = 0;
        to_neg();
        chk("r5 still full", 32'(iss_full), 32'd1);
        to_next();
        for (int j = 0; j < 3; j++) begin
            wb_en = 1; wb_addr = 5; wb_data = 32'h510 + 32'(j);
            to_neg();
            chk($sformatf("r5 drain%0d busy0", j), 32'(rd_busy[0]), (j == 2) ? 32'd0 : 32'd1);
            to_next();
        end
        wb_en = 0;
        to_neg();
        chk("r5 drained data", rd_data[31:0], 32'h512);
        to_next();

        // Frozen issue plus orphan writeback.
        freeze = 1; iss_en = 1; iss_addr = 2;
        wb_en = 1; wb_addr = 2; wb_data = 32'h22; set_rd(2, 2, 2);
        to_neg();
        chk("orphan sb_err same cycle", 32'(sb_err), 32'd0);
        to_next();
        idle();
        to_neg();
        chk("orphan sb_err", 32'(sb_err), 32'd1);
        chk("orphan rd_data0", rd_data[31:0], 32'h22);
        chk("frozen busy", 32'(rd_busy), 32'd0);
        to_next();

        // Flush with concurrent writeback.
        iss_en = 1; iss_addr = 1;
        to_next();
        iss_addr = 4;
        to_next();
        iss_en = 0; set_rd(1, 4, 6);
        to_neg();
        chk("pre-flush busy", 32'(rd_busy), 32'd3);
        to_next();
        flush = 1; wb_en = 1; wb_addr = 4; wb_data = 32'h44; iss_en = 1; iss_addr = 6;
        to_next();
        idle();
        to_neg();
        chk("flush busy", 32'(rd_busy), 32'd0);
        chk("flush rd_data1", rd_data[63:32], 32'h44);
        chk("flush sb_err", 32'(sb_err), 32'd1);
        to_next();

        // Reset mid-sequence overrides writeback and issue.
        iss_en = 1; iss_addr = 7;
        to_next();
        iss_en = 0; wb_en = 1; wb_addr = 9; wb_data = 32'h99;
        to_next();
        rst = 1; wb_en = 1; wb_addr = 9; wb_data = 32'hAA; iss_en = 1; iss_addr = 7;
        to_next();
        idle(); set_rd(9, 7, 4);
        to_neg();
        chk("rst rd_data0", rd_data[31:0], 32'd9);
        chk("rst rd_data1", rd_data[63:32], 32'd7);
        chk("rst rd_data2", rd_data[95:64], 32'd4);
        chk("rst busy", 32'(rd_busy), 32'd0);
        chk("rst sb_err", 32'(sb_err), 32'd0);
        to_next();
        to_next();

        armed = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
